// File: rtl/dmux_stream.sv
// dmux_stream: registered 1-to-N stream demultiplexer with per-channel
// valid/ready, unicast or broadcast routing, and drop accounting for
// out-of-range unicast destinations.
module dmux_stream #(
  parameter  int unsigned N  = 4,
  parameter  int unsigned W  = 8,
  parameter  int unsigned CW = 8,
  localparam int unsigned SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic [SW-1:0] in_sel,
  input  logic          in_bcast,
  output logic [N-1:0]  out_valid,
  input  logic [N-1:0]  out_ready,
  output logic [W-1:0]  out_data,
  output logic          err,
  output logic [CW-1:0] drop_cnt
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic [W-1:0]  data_q,     data_d;
  logic [N-1:0]  pend_q,     pend_d;
  logic          err_q,      err_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  logic [N-1:0]  pend_next_c;
  logic [N-1:0]  onehot_c;
  logic          sel_oob_c;
  logic          accept_c;

  // Channels still owed the held word once this cycle's transfers complete
  always_comb begin
    pend_next_c = pend_q & ~out_ready;
  end

  // Decode the unicast destination and flag selections beyond the last channel
  always_comb begin
    onehot_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      onehot_c[i] = (32'(in_sel) == i);
    end
    sel_oob_c = !in_bcast && (32'(in_sel) >= N);
  end

  // Accept a new word when nothing would remain owed after this cycle
  always_comb begin
    accept_c = in_valid && (pend_next_c == '0);
  end

  // Next-state: load on accept (drop out-of-range unicast), otherwise retire transfers
  always_comb begin
    data_d     = data_q;
    pend_d     = pend_next_c;
    err_d      = 1'b0;
    drop_cnt_d = drop_cnt_q;
    if (accept_c) begin
      data_d = in_data;
      if (in_bcast) begin
        pend_d = '1;
      end else if (sel_oob_c) begin
        pend_d = '0;
        err_d  = 1'b1;
        if (drop_cnt_q != CNT_MAX) begin
          drop_cnt_d = drop_cnt_q + CW'(1);
        end
      end else begin
        pend_d = onehot_c;
      end
    end
  end

  // State registers with synchronous reset; reset discards any held word
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q     <= '0;
      pend_q     <= '0;
      err_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      data_q     <= data_d;
      pend_q     <= pend_d;
      err_q      <= err_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign in_ready  = (pend_next_c == '0);
  assign out_valid = pend_q;
  assign out_data  = data_q;
  assign err       = err_q;
  assign drop_cnt  = drop_cnt_q;

endmodule
